// File: rtl/fir_out_pkg.sv
// +--------------------------------------------------------------------------+
// | fir_out_pkg : shared types and round/saturate helpers for fir_out_requant |
// | Revision    : 1.0                                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package fir_out_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [31:0] acc_t;
  typedef logic signed [32:0] wide_t;

  localparam sample_t SAT_MAX = 16'sh7FFF;
  localparam sample_t SAT_MIN = 16'sh8000;

  // One guard bit above the accumulator so the rounding offset cannot wrap.
  function automatic wide_t round_shift(acc_t y, int shift);
    wide_t t;
    t = wide_t'(y) + (wide_t'(1) <<< (shift - 1));
    return t >>> shift;
  endfunction

  function automatic logic is_sat(wide_t r);
    return (r > wide_t'(SAT_MAX)) || (r < wide_t'(SAT_MIN));
  endfunction

  function automatic sample_t round_sat(acc_t y, int shift);
    wide_t r;
    r = round_shift(y, shift);
    if (r > wide_t'(SAT_MAX)) return SAT_MAX;
    else if (r < wide_t'(SAT_MIN)) return SAT_MIN;
    else return r[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_out_fifo.sv
// +--------------------------------------------------------------------------+
// | fir_out_fifo : first-word-fall-through sync FIFO with flush and level     |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_out_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop, do_push;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  // A pop frees the slot in the same edge, so a push into a full FIFO still lands.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q[AW-1:0]] = wdata_i;
        wr_d = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_out_requant.sv
// +--------------------------------------------------------------------------+
// | fir_out_requant : round/shift/saturate FIR output into a FWFT FIFO.       |
// | Optional stats counters with FIR_OUT_STATS_EN.  Revision : 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_out_requant
  import fir_out_pkg::*;
#(
  parameter int SHIFT = 15,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_strobe_i,
  input  logic [31:0]              y_i,
  input  logic                     clear_i,
  output logic [15:0]              out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
`ifdef FIR_OUT_STATS_EN
  ,
  output logic [15:0]              sat_count_o,
  output logic [15:0]              drop_count_o
`endif
);

  logic    s1_valid_q, s1_valid_d;
  sample_t s1_data_q, s1_data_d;
  logic    overflow_q, overflow_d;
  logic    fifo_full, fifo_empty, pop, drop, s1_sat;

  assign pop  = out_ready_i & ~fifo_empty;
  assign drop = s1_valid_q & fifo_full & ~pop & ~clear_i;
  assign s1_sat = is_sat(round_shift(y_i, SHIFT));

  always_comb begin
    s1_valid_d = valid_strobe_i & ~clear_i;
    s1_data_d  = s1_valid_d ? round_sat(y_i, SHIFT) : s1_data_q;
    overflow_d = clear_i ? 1'b0 : (overflow_q | drop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      overflow_q <= overflow_d;
    end
  end

  fir_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (clear_i),
    .push_i  (s1_valid_q),
    .wdata_i (s1_data_q),
    .pop_i   (out_ready_i),
    .rdata_o (out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  assign out_valid_o = ~fifo_empty;
  assign overflow_o  = overflow_q;

`ifdef FIR_OUT_STATS_EN
  logic [15:0] sat_count_q, sat_count_d, drop_count_q, drop_count_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    sat_count_d  = sat_count_q;
    drop_count_d = drop_count_q;
    if (clear_i) begin
      sat_count_d  = '0;
      drop_count_d = '0;
    end else begin
      if (s1_valid_d && s1_sat && (sat_count_q != 16'hFFFF))
        sat_count_d = sat_count_q + 16'd1;
      if (drop && (drop_count_q != 16'hFFFF))
        drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sat_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      sat_count_q  <= sat_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign sat_count_o  = sat_count_q;
  assign drop_count_o = drop_count_q;
`else
  logic unused_sat;
  assign unused_sat = s1_sat;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_out_requant.sv
// +--------------------------------------------------------------------------+
// | tb_fir_out_requant : self-checking bench with queue-based reference model |
// | Revision           : 1.0                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_fir_out_requant;

  localparam int SHIFT = 15;
  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_strobe_i = 1'b0;
  logic [31:0] y_i = '0;
  logic        clear_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        overflow_o;
  logic [3:0]  level_o;
`ifdef FIR_OUT_STATS_EN
  logic [15:0] sat_count_o, drop_count_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  fir_out_requant #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_strobe_i (valid_strobe_i),
    .y_i            (y_i),
    .clear_i        (clear_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .overflow_o     (overflow_o),
    .level_o        (level_o)
`ifdef FIR_OUT_STATS_EN
    ,
    .sat_count_o    (sat_count_o),
    .drop_count_o   (drop_count_o)
`endif
  );

  // Reference model state: one pending stage-1 word plus a queue for the FIFO.
  logic        ms1v;
  logic [15:0] ms1d;
  logic [15:0] mq[$];
  logic        movf;
  int          msat, mdrop;

  function automatic longint ref_q(input logic [31:0] y);
    longint v, num, q, den;
    den = longint'(1) << SHIFT;
    v   = longint'($signed(y));
    num = v + den / 2;
    q   = num / den;
    if (num < 0 && (num % den) != 0) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] ref_rs(input logic [31:0] y);
    longint q;
    q = ref_q(y);
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    return q[15:0];
  endfunction

  function automatic logic ref_is_sat(input logic [31:0] y);
    longint q;
    q = ref_q(y);
    return (q > 32767) || (q < -32768);
  endfunction

  task automatic model_reset();
    ms1v = 1'b0; ms1d = '0; mq.delete(); movf = 1'b0; msat = 0; mdrop = 0;
  endtask

  task automatic model_edge(input logic s, input logic [31:0] y, input logic r, input logic c);
    logic pop;
    if (c) begin
      model_reset();
      return;
    end
    pop = r && (mq.size() > 0);
    if (pop) void'(mq.pop_front());
    if (ms1v) begin
      if (mq.size() < DEPTH) mq.push_back(ms1d);
      else begin
        movf = 1'b1;
        if (mdrop < 65535) mdrop++;
      end
    end
    ms1v = s;
    if (s) begin
      ms1d = ref_rs(y);
      if (ref_is_sat(y) && msat < 65535) msat++;
    end
  endtask

  task automatic cyc(input logic s, input logic [31:0] y, input logic r, input logic c);
    valid_strobe_i = s; y_i = y; out_ready_i = r; clear_i = c;
    @(posedge clk_i);
    model_edge(s, y, r, c);
    #1;
    valid_strobe_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid_o !== 1'b0 || level_o !== 4'd0 || overflow_o !== 1'b0 || out_data_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_init: valid=%b level=%0d ovf=%b data=%h required 0/0/0/0000",
               out_valid_o, level_o, overflow_o, out_data_o);
    end
    @(posedge clk_i); #1; rst_i = 1'b0; model_reset();
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (level_o !== 4'd3) begin
      errors++;
      $display("FAIL reset_prefill: level=%0d required 3", level_o);
    end
    #2; rst_i = 1'b1; #1;
    checks++;
    if (out_valid_o !== 1'b0 || level_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%b level=%0d required 0/0", out_valid_o, level_o);
    end
    @(posedge clk_i); #1; rst_i = 1'b0; model_reset();
  endtask

  task automatic test_rounding();
    logic [31:0] ys [4];
    logic [15:0] ex [4];
    ys = '{32'h0000_4000, 32'h0000_3FFF, 32'hFFFF_C000, 32'hFFFF_BFFF};
    ex = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, ys[i], 0, 0);
      checks++;
      if (out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL round_latency%0d: valid=%b one cycle after strobe, required 0", i, out_valid_o);
      end
      cyc(0, 0, 0, 0);
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== ex[i]) begin
        errors++;
        $display("FAIL round%0d: valid=%b data=%h required 1/%h", i, out_valid_o, out_data_o, ex[i]);
      end
      cyc(0, 0, 1, 0);
    end
  endtask

  task automatic test_saturation();
    cyc(0, 0, 0, 1);
    cyc(1, 32'h7FFF_FFFF, 0, 0);
    cyc(1, 32'h8000_0000, 0, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (level_o !== 4'd2 || out_data_o !== 16'h7FFF) begin
      errors++;
      $display("FAIL sat_pos: level=%0d data=%h required 2/7fff", level_o, out_data_o);
    end
    cyc(0, 0, 1, 0);
    checks++;
    if (out_valid_o !== 1'b1 || out_data_o !== 16'h8000) begin
      errors++;
      $display("FAIL sat_neg: valid=%b data=%h required 1/8000", out_valid_o, out_data_o);
    end
`ifdef FIR_OUT_STATS_EN
    checks++;
    if (sat_count_o !== 16'd2) begin
      errors++;
      $display("FAIL sat_count: got %0d required 2", sat_count_o);
    end
`endif
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    logic [31:0] ys [9];
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      ys[i] = $urandom;
      cyc(1, ys[i], 0, 0);
    end
    checks++;
    if (level_o !== 4'd8 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL ovf_before: level=%0d ovf=%b required 8/0", level_o, overflow_o);
    end
    cyc(0, 0, 0, 0);
    checks++;
    if (level_o !== 4'd8 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: level=%0d ovf=%b required 8/1", level_o, overflow_o);
    end
`ifdef FIR_OUT_STATS_EN
    checks++;
    if (drop_count_o !== 16'd1) begin
      errors++;
      $display("FAIL drop_count: got %0d required 1", drop_count_o);
    end
`endif
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== ref_rs(ys[k])) begin
        errors++;
        $display("FAIL ovf_order%0d: valid=%b data=%h required 1/%h", k, out_valid_o, out_data_o, ref_rs(ys[k]));
      end
      cyc(0, 0, 1, 0);
    end
    checks++;
    if (level_o !== 4'd0 || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: level=%0d ovf=%b required 0/1", level_o, overflow_o);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] ys [8];
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      ys[i] = $urandom;
      cyc(1, ys[i], 0, 0);
    end
    cyc(1, $urandom, 0, 0);
    checks++;
    if (level_o !== 4'd8) begin
      errors++;
      $display("FAIL full_fill: level=%0d required 8", level_o);
    end
    cyc(0, 0, 1, 0);
    checks++;
    if (level_o !== 4'd8 || overflow_o !== 1'b0 || out_data_o !== ref_rs(ys[1])) begin
      errors++;
      $display("FAIL full_pop: level=%0d ovf=%b data=%h required 8/0/%h",
               level_o, overflow_o, out_data_o, ref_rs(ys[1]));
    end
  endtask

  task automatic test_clear();
    cyc(1, $urandom, 0, 0);
    cyc(0, 0, 0, 0);
    checks++;
    if (overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL clear_pre: ovf=%b required 1", overflow_o);
    end
    cyc(1, 32'h1234_5678, 0, 1);
    checks++;
    if (level_o !== 4'd0 || out_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL clear: level=%0d valid=%b ovf=%b required 0/0/0", level_o, out_valid_o, overflow_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      checks++;
      if (level_o !== 4'd0 || out_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL clear_after%0d: level=%0d valid=%b required 0/0", i, level_o, out_valid_o);
      end
    end
  endtask

  task automatic test_random();
    logic s, r, c;
    logic [31:0] y;
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 40);
      c = ($urandom_range(0, 99) < 2);
      case ($urandom_range(0, 3))
        0: y = {{2{$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0}}, 30'($urandom)};
        1: y = 32'($signed(16'($urandom))) <<< 15;
        default: y = $urandom;
      endcase
      cyc(s, y, r, c);
      checks++;
      if (level_o !== 4'(mq.size()) || out_valid_o !== (mq.size() > 0) || overflow_o !== movf) begin
        errors++;
        $display("FAIL rand_state@%0d: level=%0d valid=%b ovf=%b required %0d/%b/%b",
                 i, level_o, out_valid_o, overflow_o, mq.size(), mq.size() > 0, movf);
      end
      if (mq.size() > 0) begin
        checks++;
        if (out_data_o !== mq[0]) begin
          errors++;
          $display("FAIL rand_data@%0d: data=%h required %h", i, out_data_o, mq[0]);
        end
      end
`ifdef FIR_OUT_STATS_EN
      checks++;
      if (sat_count_o !== 16'(msat) || drop_count_o !== 16'(mdrop)) begin
        errors++;
        $display("FAIL rand_stats@%0d: sat=%0d drop=%0d required %0d/%0d",
                 i, sat_count_o, drop_count_o, msat, mdrop);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_pop();
    test_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
